mac_integrator_v2: RTL and testbench

Parametrised successor integrator placed after the photonic MAC receive path. It applies a per-lane sparsity mask and per-lane sign to LANES unsigned samples, then reduces them with a fully pipelined adder tree. Tree sums are accumulated over a configurable number of input beats per output, and each result is scaled and saturated to OUT_WIDTH. Unlike the previous generation it tolerates input gaps, applies sparsity, saturates, and frames each job with start/tlast/done.

---
 rtl/mac_integrator_v2.sv | 186 ++++++++++++++++++
 tb/tb_mac_integrator_v2.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_integrator_v2.sv
// mac_integrator_v2
// Masks, signs and sums LANES unsigned samples per beat through a registered
// adder tree. Tree sums are accumulated over a configured number of beats,
// and each group result is shifted and saturated to OUT_WIDTH.
//
// State table:
//   IDLE  | waiting for cfg_start; no beats accepted
//   RUN   | accepting beats until the last beat of the last group
//   DRAIN | pipeline flushing; leaves on the cycle the final result is emitted
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_tdata/s_sparsity/s_sign/s_tvalid/s_tready   input beat stream
//   cfg_start, cfg_num_input_cycles, cfg_num_outputs, cfg_shift   job config
//   m_tdata/m_tvalid/m_tlast/m_sat                result stream
//   busy, done               job status
module mac_integrator_v2 #(
  parameter int LOG2_LANES  = 4,
  parameter int VALUE_WIDTH = 16,
  parameter int ACC_WIDTH   = 24,
  parameter int OUT_WIDTH   = 16,
  parameter int CNT_WIDTH   = 10
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [(VALUE_WIDTH<<LOG2_LANES)-1:0]   s_tdata,
  input  logic [(1<<LOG2_LANES)-1:0]             s_sparsity,
  input  logic [(1<<LOG2_LANES)-1:0]             s_sign,
  input  logic                                   s_tvalid,
  output logic                                   s_tready,
  input  logic                                   cfg_start,
  input  logic [CNT_WIDTH-1:0]                   cfg_num_input_cycles,
  input  logic [CNT_WIDTH-1:0]                   cfg_num_outputs,
  input  logic [4:0]                             cfg_shift,
  output logic [OUT_WIDTH-1:0]                   m_tdata,
  output logic                                   m_tvalid,
  output logic                                   m_tlast,
  output logic                                   m_sat,
  output logic                                   busy,
  output logic                                   done
);

  localparam int LANES = 1 << LOG2_LANES;
  localparam int L     = LOG2_LANES;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [CNT_WIDTH-1:0] cyc_lat, outs_lat, beat_cnt, out_cnt;
  logic [4:0]           shift_lat;
  logic                 accept, group_end, job_end, start_job, start_empty;

  logic signed [ACC_WIDTH-1:0] term [LANES];
  logic signed [ACC_WIDTH-1:0] tree [0:L][0:LANES-1];
  logic [L:0]                  t_vld, t_first, t_end, t_last;

  logic signed [ACC_WIDTH-1:0] acc, shifted;
  logic                        acc_vld, acc_last, sat_hi, sat_lo;

  assign s_tready    = (state == RUN);
  assign busy        = (state != IDLE);
  assign accept      = s_tvalid && s_tready;
  assign group_end   = accept && ((beat_cnt + CNT_ONE) == cyc_lat);
  assign job_end     = group_end && ((out_cnt + CNT_ONE) == outs_lat);
  assign start_job   = (state == IDLE) && cfg_start && (cfg_num_outputs != '0);
  assign start_empty = (state == IDLE) && cfg_start && (cfg_num_outputs == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_job) state_nxt = RUN;
      RUN:     if (job_end) state_nxt = DRAIN;
      DRAIN:   if (acc_vld && acc_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Config latch and beat/output counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_lat   <= '0;
      outs_lat  <= '0;
      shift_lat <= '0;
      beat_cnt  <= '0;
      out_cnt   <= '0;
    end else if (start_job) begin
      cyc_lat   <= (cfg_num_input_cycles == '0) ? CNT_ONE : cfg_num_input_cycles;
      outs_lat  <= cfg_num_outputs;
      shift_lat <= cfg_shift;
      beat_cnt  <= '0;
      out_cnt   <= '0;
    end else if (accept) begin
      if (group_end) begin
        beat_cnt <= '0;
        out_cnt  <= out_cnt + CNT_ONE;
      end else begin
        beat_cnt <= beat_cnt + CNT_ONE;
      end
    end
  end

  always_comb begin
    for (int g = 0; g < LANES; g++) begin
      term[g] = '0;
      if (s_sparsity[g]) begin
        if (s_sign[g]) term[g] =  ACC_WIDTH'(s_tdata[g*VALUE_WIDTH +: VALUE_WIDTH]);
        else           term[g] = -ACC_WIDTH'(s_tdata[g*VALUE_WIDTH +: VALUE_WIDTH]);
      end
    end
  end

  // Tree data runs free; the flag pipeline below qualifies it. The upper
  // half of every level past the first is tied to zero so the array is
  // fully driven.
  always_ff @(posedge clk) begin
    for (int g = 0; g < LANES; g++) tree[0][g] <= term[g];
    for (int k = 0; k < L; k++) begin
      for (int i = 0; i < LANES/2; i++) begin
        tree[k+1][i]         <= tree[k][2*i] + tree[k][2*i+1];
        tree[k+1][i+LANES/2] <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_vld   <= '0;
      t_first <= '0;
      t_end   <= '0;
      t_last  <= '0;
    end else begin
      t_vld   <= {t_vld[L-1:0],   accept};
      t_first <= {t_first[L-1:0], beat_cnt == '0};
      t_end   <= {t_end[L-1:0],   group_end};
      t_last  <= {t_last[L-1:0],  job_end};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      acc_vld  <= 1'b0;
      acc_last <= 1'b0;
    end else begin
      acc_vld  <= t_vld[L] && t_end[L];
      acc_last <= t_vld[L] && t_last[L];
      if (t_vld[L]) acc <= (t_first[L] ? '0 : acc) + tree[L][0];
    end
  end

  assign shifted = acc >>> shift_lat;
  assign sat_hi  = shifted > OUT_MAX;
  assign sat_lo  = shifted < OUT_MIN;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_sat    <= 1'b0;
      done     <= 1'b0;
    end else begin
      m_tvalid <= acc_vld;
      m_tlast  <= acc_vld && acc_last;
      m_sat    <= acc_vld && (sat_hi || sat_lo);
      done     <= start_empty || (m_tvalid && m_tlast);
      if (acc_vld) begin
        if (sat_hi)      m_tdata <= OUT_MAX[OUT_WIDTH-1:0];
        else if (sat_lo) m_tdata <= OUT_MIN[OUT_WIDTH-1:0];
        else             m_tdata <= shifted[OUT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mac_integrator_v2.sv
// Testbench for mac_integrator_v2: directed table of jobs plus randomized
// jobs checked against a sum/shift/clip reference model with timing queue.
module tb_mac_integrator_v2;

  localparam int LANES = 16;
  localparam int VW    = 16;
  localparam int MAXB  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [LANES*VW-1:0] s_tdata;
  logic [LANES-1:0]  s_sparsity, s_sign;
  logic              s_tvalid, s_tready;
  logic              cfg_start;
  logic [9:0]        cfg_num_input_cycles, cfg_num_outputs;
  logic [4:0]        cfg_shift;
  logic [15:0]       m_tdata;
  logic              m_tvalid, m_tlast, m_sat, busy, done;

  mac_integrator_v2 dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_sparsity(s_sparsity), .s_sign(s_sign),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .cfg_start(cfg_start), .cfg_num_input_cycles(cfg_num_input_cycles),
    .cfg_num_outputs(cfg_num_outputs), .cfg_shift(cfg_shift),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_sat(m_sat), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int     t;
    longint val;
    bit     sat;
    bit     last;
  } exp_t;
  exp_t expq[$];
  int   exp_done_t = -1;

  typedef struct {
    logic [15:0] vlo, vhi, sign, spar;
    int          cyc, outs, shift;
    logic [7:0]  vpat;
    int          plen;
    longint      exp_val;
    bit          exp_sat;
  } vec_t;
  vec_t tab[8];

  logic [15:0] bv  [0:MAXB-1][0:LANES-1];
  logic [15:0] bsg [0:MAXB-1];
  logic [15:0] bsp [0:MAXB-1];

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic longint lane_sum(input int idx);
    longint s = 0;
    for (int l = 0; l < LANES; l++)
      if (bsp[idx][l]) s += bsg[idx][l] ? longint'(bv[idx][l]) : -longint'(bv[idx][l]);
    return s;
  endfunction

  task automatic model_out(input longint s, input int sh, output longint v, output bit sat);
    longint r;
    r = s >>> sh;
    sat = 1'b0;
    v = r;
    if (r > 32767)       begin v = 32767;  sat = 1'b1; end
    else if (r < -32768) begin v = -32768; sat = 1'b1; end
  endtask

  // Output monitor: every result must appear exactly on its predicted cycle
  always @(negedge clk) begin
    logic [15:0] ev;
    bit          exp_d;
    if (expq.size() > 0 && expq[0].t == cyc) begin
      ev = expq[0].val[15:0];
      checks++;
      if (!(m_tvalid === 1'b1 && m_tdata === ev && m_sat === expq[0].sat &&
            m_tlast === expq[0].last)) begin
        errors++;
        $display("FAIL result: got v=%0b d=%0d sat=%0b last=%0b expected v=1 d=%0d sat=%0b last=%0b (cycle %0d)",
                 m_tvalid, $signed(m_tdata), m_sat, m_tlast, $signed(ev), expq[0].sat, expq[0].last, cyc);
      end
      void'(expq.pop_front());
    end else if (m_tvalid || m_tlast || m_sat) begin
      checks++;
      errors++;
      $display("FAIL spurious_out: got v=%0b last=%0b sat=%0b expected all 0 (cycle %0d)",
               m_tvalid, m_tlast, m_sat, cyc);
    end
    exp_d = (cyc == exp_done_t);
    if (done || exp_d) begin
      checks++;
      if (done !== exp_d) begin
        errors++;
        $display("FAIL done: got %0b expected %0b (cycle %0d)", done, exp_d, cyc);
      end
    end
  end

  task automatic drive_beat(input int idx, input bit v);
    for (int l = 0; l < LANES; l++) s_tdata[l*VW +: VW] = bv[idx][l];
    s_sign     = bsg[idx];
    s_sparsity = bsp[idx];
    s_tvalid   = v;
  endtask

  task automatic fill_table_beats(input vec_t e);
    for (int i = 0; i < MAXB; i++) begin
      for (int l = 0; l < LANES; l++) bv[i][l] = (l < 8) ? e.vlo : e.vhi;
      bsg[i] = e.sign;
      bsp[i] = e.spar;
    end
  endtask

  task automatic run_job(input int cyc_cfg, input int outs, input int sh,
                         input logic [7:0] vpat, input int plen, input bit rnd_valid,
                         input bit use_tab, input longint tval, input bit tsat);
    int cy, total, idx, step, gbeat, gcount;
    longint gsum, mv;
    bit v, ms;
    exp_t e;
    cy = (cyc_cfg == 0) ? 1 : cyc_cfg;
    total = cy * outs;
    @(negedge clk);
    chk("busy_before_start", busy, 0);
    cfg_num_input_cycles = 10'(cyc_cfg);
    cfg_num_outputs      = 10'(outs);
    cfg_shift            = 5'(sh);
    cfg_start            = 1'b1;
    s_tvalid             = 1'b0;
    if (outs == 0) exp_done_t = cyc + 1;
    @(negedge clk);
    cfg_start            = 1'b0;
    cfg_num_input_cycles = 10'($urandom_range(0, 1023));
    cfg_num_outputs      = 10'($urandom_range(0, 1023));
    cfg_shift            = 5'($urandom_range(0, 31));
    idx = 0; step = 0; gsum = 0; gbeat = 0; gcount = 0;
    while (idx < total) begin
      chk("tready_run", s_tready, 1);
      chk("busy_run", busy, 1);
      v = rnd_valid ? ($urandom_range(0, 2) != 0) : vpat[step % plen];
      drive_beat(idx, v);
      if (v) begin
        gsum += lane_sum(idx);
        gbeat++;
        if (gbeat == cy) begin
          gcount++;
          if (use_tab) begin mv = tval; ms = tsat; end
          else model_out(gsum, sh, mv, ms);
          e.t = cyc + 7; e.val = mv; e.sat = ms; e.last = (gcount == outs);
          expq.push_back(e);
          if (e.last) exp_done_t = cyc + 8;
          gsum = 0; gbeat = 0;
        end
        idx++;
      end
      step++;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      chk("tready_closed", s_tready, 0);
      drive_beat($urandom_range(0, MAXB-1), 1'b1);
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (expq.size() == 0 && cyc > exp_done_t) break;
      @(negedge clk);
    end
    if (expq.size() != 0 || cyc <= exp_done_t) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", expq.size());
      expq.delete();
    end
    chk("busy_after", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //            vlo    vhi    sign      spar      cyc outs sh  vpat        plen  exp     sat
    tab[0] = '{16'd1,    16'd1,    16'hFFFF, 16'hFFFF, 3, 2, 0, 8'h01,       1, 48,     0};
    tab[1] = '{16'd100,  16'd30,   16'h00FF, 16'hFFFF, 1, 4, 0, 8'h01,       1, 560,    0};
    tab[2] = '{16'd1000, 16'd1000, 16'hFFFF, 16'h000F, 2, 1, 0, 8'h01,       1, 8000,   0};
    tab[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4, 1, 0, 8'h01,       1, 32767,  1};
    tab[4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4, 1, 8, 8'h01,       1, 16383,  0};
    tab[5] = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, 4, 1, 0, 8'h01,       1, -32768, 1};
    tab[6] = '{16'd1,    16'd1,    16'hFFFF, 16'hFFFF, 3, 2, 0, 8'b00101001, 6, 48,     0};
    tab[7] = '{16'd2,    16'd2,    16'hFFFF, 16'hFFFF, 0, 2, 0, 8'h01,       1, 32,     0};

    rst = 1'b1; cfg_start = 1'b0; s_tvalid = 1'b0; s_tdata = '0;
    s_sparsity = '0; s_sign = '0; cfg_num_input_cycles = '0;
    cfg_num_outputs = '0; cfg_shift = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      fill_table_beats(tab[i]);
      run_job(tab[i].cyc, tab[i].outs, tab[i].shift, tab[i].vpat, tab[i].plen,
              1'b0, 1'b1, tab[i].exp_val, tab[i].exp_sat);
    end

    // Reset in the middle of a job: nothing may come out
    fill_table_beats(tab[0]);
    @(negedge clk);
    cfg_num_input_cycles = 10'd3; cfg_num_outputs = 10'd2; cfg_shift = 5'd0;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    drive_beat(0, 1'b1);
    @(negedge clk);
    drive_beat(1, 1'b1);
    @(negedge clk);
    s_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_tready", s_tready, 0);
    repeat (12) @(negedge clk);

    run_job(5, 0, 0, 8'h01, 1, 1'b0, 1'b0, 0, 0);
    chk("empty_job_busy", busy, 0);

    fill_table_beats(tab[0]);
    run_job(3, 2, 0, 8'h01, 1, 1'b0, 1'b1, 48, 0);

    // Randomized jobs against the reference model
    for (int j = 0; j < 8; j++) begin
      int rc, ro, rs;
      rc = $urandom_range(0, 4);
      ro = $urandom_range(1, 4);
      rs = $urandom_range(0, 6);
      for (int i = 0; i < MAXB; i++) begin
        for (int l = 0; l < LANES; l++)
          bv[i][l] = (j[0]) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 300));
        bsg[i] = 16'($urandom_range(0, 65535));
        bsp[i] = 16'($urandom_range(0, 65535));
      end
      run_job(rc, ro, rs, 8'h01, 1, 1'b1, 1'b0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
